// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port among NUM_REQ writeback sources.
// Define REGFILE_WB_SCOREBOARD_EN to add busy-bit tracking and read-after-write hazard flags.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      we,
    output logic [ADDR_W-1:0]         waddr,
    output logic [DATA_W-1:0]         wdata,
    output logic [2:0]                grant_id,
    input  logic                      reserve_vld,
    input  logic [ADDR_W-1:0]         reserve_addr,
    input  logic [ADDR_W-1:0]         rd_addr1,
    input  logic [ADDR_W-1:0]         rd_addr2,
    output logic                      hazard1,
    output logic                      hazard2
);

    logic [2:0]         r_ptr;
    logic               r_we;
    logic [ADDR_W-1:0]  r_waddr;
    logic [DATA_W-1:0]  r_wdata;
    logic [2:0]         r_grant_id;

    logic               w_found;
    logic [2:0]         w_sel;
    logic [2:0]         w_ptr_next;
    logic [NUM_REQ-1:0] w_grant;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_data;
    logic               w_xfer;

    // Scan offsets from the pointer; every index is a constant so the selection unrolls into a mux tree.
    always_comb begin
        w_found    = 1'b0;
        w_sel      = '0;
        w_ptr_next = r_ptr;
        w_grant    = '0;
        w_addr     = '0;
        w_data     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_found && req_valid[i] && ((int'(r_ptr) + k) % NUM_REQ) == i) begin
                    w_found    = 1'b1;
                    w_sel      = 3'(i);
                    w_ptr_next = 3'((i + 1) % NUM_REQ);
                    w_grant[i] = 1'b1;
                    w_addr     = req_addr[i*ADDR_W +: ADDR_W];
                    w_data     = req_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign w_xfer    = w_found && !rst;
    assign req_ready = rst ? '0 : w_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= '0;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_grant_id <= '0;
        end else if (w_xfer) begin
            r_ptr      <= w_ptr_next;
            r_we       <= (w_addr != '0);
            r_waddr    <= w_addr;
            r_wdata    <= w_data;
            r_grant_id <= w_sel;
        end else begin
            r_we <= 1'b0;
        end
    end

    assign we       = r_we;
    assign waddr    = r_waddr;
    assign wdata    = r_wdata;
    assign grant_id = r_grant_id;

`ifdef REGFILE_WB_SCOREBOARD_EN
    localparam int NUM_REGS = 2**ADDR_W;

    logic [NUM_REGS-1:0] r_busy;

    // A reservation wins over a same-cycle commit: the new producer is still outstanding.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                always_ff @(posedge clk) begin
                    r_busy[gi] <= 1'b0;
                end
            end else begin : g_reg
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_busy[gi] <= 1'b0;
                    end else if (reserve_vld && reserve_addr == ADDR_W'(gi)) begin
                        r_busy[gi] <= 1'b1;
                    end else if (r_we && r_waddr == ADDR_W'(gi)) begin
                        r_busy[gi] <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    assign hazard1 = (rd_addr1 != '0) && r_busy[rd_addr1] && !(r_we && r_waddr == rd_addr1);
    assign hazard2 = (rd_addr2 != '0) && r_busy[rd_addr2] && !(r_we && r_waddr == rd_addr2);
`else
    logic w_unused;
    assign w_unused = ^{reserve_vld, reserve_addr, rd_addr1, rd_addr2};
    assign hazard1  = 1'b0;
    assign hazard2  = 1'b0;
`endif

endmodule
